// File: rtl/memc_rst_pkg.sv
// Shared definitions for the memory-controller reset sequencer.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents:
//   seq_state_e  - sequencer state enum; its 3-bit value is what seq_state shows
//   ST_*         - the same encoding as plain localparam constants for the FSM
//   LOCK_CNT_W   - width of the saturating lock-loss counter
//   cnt_width()  - smallest register width able to hold 0..max_count
package memc_rst_pkg;

  localparam int LOCK_CNT_W = 8;

  typedef enum logic [2:0] {
    SEQ_ASSERT     = 3'd0,
    SEQ_WAIT_LOCK  = 3'd1,
    SEQ_RELEASE    = 3'd2,
    SEQ_WAIT_CALIB = 3'd3,
    SEQ_RUN        = 3'd4
  } seq_state_e;

  localparam logic [2:0] ST_ASSERT     = SEQ_ASSERT;
  localparam logic [2:0] ST_WAIT_LOCK  = SEQ_WAIT_LOCK;
  localparam logic [2:0] ST_RELEASE    = SEQ_RELEASE;
  localparam logic [2:0] ST_WAIT_CALIB = SEQ_WAIT_CALIB;
  localparam logic [2:0] ST_RUN        = SEQ_RUN;

  // Width needed to count from 0 up to and including max_count, never below 1.
  function automatic int cnt_width(input int max_count);
    if (max_count < 2) begin
      return 1;
    end
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/memc_lock_filter.sv
// Debounce filter: reports PLL lock as stable once it has been high FILTER consecutive cycles.
// Latency: o_stable is combinational and rises during the FILTER-th consecutive high cycle.
// Backpressure: none; any low cycle or i_clr restarts the count.
//
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   synchronous active-low reset
//   i_clr     synchronous clear of the run-length count (consumer not listening)
//   i_lock    PLL lock, already synchronous to i_clk
//   o_stable  high on the cycle the consecutive-high run reaches FILTER (and beyond)
module memc_lock_filter
  import memc_rst_pkg::*;
#(
  parameter int FILTER = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_lock,
  output logic o_stable
);

  localparam int CW = cnt_width(FILTER);

  logic [CW-1:0] r_cnt;

  // Counts completed high cycles; saturates at FILTER so a long lock never wraps.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (!i_lock) begin
      r_cnt <= '0;
    end else if (r_cnt != CW'(FILTER)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The current high cycle completes the run, so the consumer can act on this edge.
  assign o_stable = i_lock && (r_cnt >= CW'(FILTER - 1));

endmodule

// File: rtl/memc_rst_sequencer.sv
// Reset sequencer: holds downstream domains in reset until PLL lock is stable, then releases them in order.
// Latency: all outputs registered; a cause sampled at an edge is visible right after that edge.
// Backpressure: none; lock loss or a soft request in RUN restarts the whole sequence.
//
// Ports:
//   sys_clk        clock, rising edge
//   sys_rst_n      synchronous active-low reset
//   pll_lock       PLL lock (synchronous to sys_clk)
//   calib_done     memory calibration complete (level)
//   soft_rst_req   single-cycle request for a full re-sequence (honoured in RUN only)
//   rst_out        per-domain active-high resets, domain 0 released first
//   all_released   high when every rst_out bit is low
//   seq_state      current state encoding (memc_rst_pkg::seq_state_e)
//   lock_loss_cnt  saturating count of lock-loss events
//   calib_timeout  sticky calibration timeout flag (only with MEMC_RST_SEQ_CALIB_TIMEOUT_EN)
//
// Build option MEMC_RST_SEQ_CALIB_TIMEOUT_EN: when defined, WAIT_CALIB is bounded by
// CALIB_TIMEOUT cycles; expiry sets calib_timeout and restarts the sequence.
module memc_rst_sequencer
  import memc_rst_pkg::*;
#(
  parameter int NUM_DOMAINS   = 4,
  parameter int MIN_ASSERT    = 4,
  parameter int LOCK_FILTER   = 16,
  parameter int STAGE_DELAY   = 8,
  parameter int CALIB_TIMEOUT = 65535
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   pll_lock,
  input  logic                   calib_done,
  input  logic                   soft_rst_req,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   all_released,
  output logic [2:0]             seq_state,
  output logic [LOCK_CNT_W-1:0]  lock_loss_cnt
`ifdef MEMC_RST_SEQ_CALIB_TIMEOUT_EN
  ,
  output logic                   calib_timeout
`endif
);

`ifdef MEMC_RST_SEQ_CALIB_TIMEOUT_EN
  localparam int TO_MAX = CALIB_TIMEOUT;
`else
  // Timeout counting is compiled out; the parameter stays so both builds
  // share one instantiation interface.
  localparam int TO_MAX = 0 * CALIB_TIMEOUT;
`endif

  // One cycle counter serves ASSERT hold, the release stage spacing and the
  // calibration timeout, since only one of them is live in any state.
  localparam int CNT_MAX_A = (MIN_ASSERT > STAGE_DELAY) ? MIN_ASSERT : STAGE_DELAY;
  localparam int CNT_MAX   = (CNT_MAX_A > TO_MAX) ? CNT_MAX_A : TO_MAX;
  localparam int CNT_W     = cnt_width(CNT_MAX);
  localparam int IDX_W     = cnt_width(NUM_DOMAINS - 1);

  logic [2:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [NUM_DOMAINS-1:0] r_rst_out;
  logic                   r_all_released;
  logic [LOCK_CNT_W-1:0]  r_lock_loss_cnt;

  logic [2:0]             w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [NUM_DOMAINS-1:0] w_rst_nxt;
  logic                   w_lock_stable;
  logic                   w_filt_clr;
  logic                   w_lock_loss;
  logic                   w_timeout;

  // The filter only accumulates while we are actually waiting for lock, so
  // every visit to WAIT_LOCK starts from a zero run length.
  assign w_filt_clr = (r_state != ST_WAIT_LOCK);

  memc_lock_filter #(
    .FILTER (LOCK_FILTER)
  ) u_lock_filter (
    .i_clk    (sys_clk),
    .i_rst_n  (sys_rst_n),
    .i_clr    (w_filt_clr),
    .i_lock   (pll_lock),
    .o_stable (w_lock_stable)
  );

  // Lock is only policed once release has begun; earlier states already hold
  // every domain in reset and the filter handles lock drops there.
  assign w_lock_loss = !pll_lock &&
                       ((r_state == ST_RELEASE) ||
                        (r_state == ST_WAIT_CALIB) ||
                        (r_state == ST_RUN));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_rst_nxt   = r_rst_out;
    w_timeout   = 1'b0;

    case (r_state)
      ST_ASSERT: begin
        w_rst_nxt = '1;
        if (r_cnt == CNT_W'(MIN_ASSERT - 1)) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_WAIT_LOCK: begin
        if (w_lock_stable) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          // With a single domain there is nothing to stage before calibration.
          w_state_nxt = (NUM_DOMAINS == 1) ? ST_WAIT_CALIB : ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        // A stage opens by releasing its domain, then waits out STAGE_DELAY
        // edges before the next domain (or calibration wait) takes over.
        if (r_cnt == '0) begin
          w_rst_nxt[r_idx] = 1'b0;
        end
        if (r_cnt == CNT_W'(STAGE_DELAY - 1)) begin
          w_cnt_nxt = '0;
          if (r_idx == IDX_W'(NUM_DOMAINS - 2)) begin
            w_state_nxt = ST_WAIT_CALIB;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_WAIT_CALIB: begin
        if (calib_done) begin
          w_rst_nxt[NUM_DOMAINS-1] = 1'b0;
          w_state_nxt              = ST_RUN;
        end
`ifdef MEMC_RST_SEQ_CALIB_TIMEOUT_EN
        else if (r_cnt == CNT_W'(CALIB_TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_ASSERT;
          w_cnt_nxt   = '0;
          w_rst_nxt   = '1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
`endif
      end

      ST_RUN: begin
        if (soft_rst_req) begin
          w_state_nxt = ST_ASSERT;
          w_cnt_nxt   = '0;
          w_rst_nxt   = '1;
        end
      end

      default: begin
        w_state_nxt = ST_ASSERT;
        w_cnt_nxt   = '0;
        w_rst_nxt   = '1;
      end
    endcase

    // Lock loss overrides everything, including a same-cycle soft request or
    // calibration completion, so it is always the one that gets counted.
    if (w_lock_loss) begin
      w_state_nxt = ST_ASSERT;
      w_cnt_nxt   = '0;
      w_rst_nxt   = '1;
      w_timeout   = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state         <= ST_ASSERT;
      r_cnt           <= '0;
      r_idx           <= '0;
      r_rst_out       <= '1;
      r_all_released  <= 1'b0;
      r_lock_loss_cnt <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_idx          <= w_idx_nxt;
      r_rst_out      <= w_rst_nxt;
      r_all_released <= (w_rst_nxt == '0);
      if (w_lock_loss && (r_lock_loss_cnt != '1)) begin
        r_lock_loss_cnt <= r_lock_loss_cnt + 1'b1;
      end
    end
  end

`ifdef MEMC_RST_SEQ_CALIB_TIMEOUT_EN
  logic r_calib_timeout;

  // Sticky: only a hard reset clears it, so software can see that a
  // recalibration was forced even after the sequence has recovered.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_calib_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_calib_timeout <= 1'b1;
    end
  end

  assign calib_timeout = r_calib_timeout;
`endif

  assign rst_out       = r_rst_out;
  assign all_released  = r_all_released;
  assign seq_state     = r_state;
  assign lock_loss_cnt = r_lock_loss_cnt;

endmodule

// File: tb/tb_memc_rst_sequencer.sv
// Testbench for memc_rst_sequencer: fixed timing table, directed corner sequences,
// then randomized stimulus checked every edge against a timing-based reference model.
module tb_memc_rst_sequencer;
  import memc_rst_pkg::*;

  localparam int ND   = 4;
  localparam int MINA = 4;
  localparam int LF   = 16;
  localparam int SD   = 8;
  localparam int CTO  = 100;

  localparam int P_ASSERT = 0;
  localparam int P_WLOCK  = 1;
  localparam int P_REL    = 2;
  localparam int P_CALIB  = 3;
  localparam int P_RUN    = 4;

  logic          sys_clk;
  logic          sys_rst_n;
  logic          pll_lock;
  logic          calib_done;
  logic          soft_rst_req;
  logic [ND-1:0] rst_out;
  logic          all_released;
  logic [2:0]    seq_state;
  logic [7:0]    lock_loss_cnt;
`ifdef MEMC_RST_SEQ_CALIB_TIMEOUT_EN
  logic          calib_timeout;
`endif

  memc_rst_sequencer #(
    .NUM_DOMAINS   (ND),
    .MIN_ASSERT    (MINA),
    .LOCK_FILTER   (LF),
    .STAGE_DELAY   (SD),
    .CALIB_TIMEOUT (CTO)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .pll_lock      (pll_lock),
    .calib_done    (calib_done),
    .soft_rst_req  (soft_rst_req),
    .rst_out       (rst_out),
    .all_released  (all_released),
    .seq_state     (seq_state),
    .lock_loss_cnt (lock_loss_cnt)
`ifdef MEMC_RST_SEQ_CALIB_TIMEOUT_EN
    ,
    .calib_timeout (calib_timeout)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;
  int e     = -1;   // edge number; 0 is the first edge with sys_rst_n = 1

  // Reference model: phase plus elapsed-edge bookkeeping.
  int            m_phase = P_ASSERT;
  int            m_t     = 0;
  int            m_run   = 0;
  int            m_cnt   = 0;
  logic [ND-1:0] m_rst   = '1;
  logic          m_to    = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, e, got, exp);
    end
  endtask

  function automatic logic [2:0] phase_code(input int p);
    case (p)
      P_ASSERT: return SEQ_ASSERT;
      P_WLOCK:  return SEQ_WAIT_LOCK;
      P_REL:    return SEQ_RELEASE;
      P_CALIB:  return SEQ_WAIT_CALIB;
      default:  return SEQ_RUN;
    endcase
  endfunction

  task automatic m_enter_assert();
    m_phase = P_ASSERT;
    m_t     = 0;
    m_rst   = '1;
  endtask

  // Advance the model by one edge using the inputs the DUT sampled at it.
  task automatic model_step();
    if (!sys_rst_n) begin
      m_enter_assert();
      m_cnt = 0;
      m_to  = 1'b0;
      m_run = 0;
      return;
    end
    if (!pll_lock && m_phase >= P_REL) begin
      if (m_cnt < 255) m_cnt++;
      m_enter_assert();
      return;
    end
    case (m_phase)
      P_ASSERT: begin
        m_t++;
        if (m_t == MINA) begin
          m_phase = P_WLOCK;
          m_run   = 0;
        end
      end
      P_WLOCK: begin
        m_run = pll_lock ? m_run + 1 : 0;
        if (m_run == LF) begin
          m_phase = P_REL;
          m_t     = 0;
        end
      end
      P_REL: begin
        m_t++;
        // Domain i is released on release edge i*SD+1.
        for (int i = 0; i < ND - 1; i++)
          if (i * SD < m_t) m_rst[i] = 1'b0;
        if (m_t == (ND - 1) * SD) begin
          m_phase = P_CALIB;
          m_t     = 0;
        end
      end
      P_CALIB: begin
        m_t++;
        if (calib_done) begin
          m_rst   = '0;
          m_phase = P_RUN;
        end
`ifdef MEMC_RST_SEQ_CALIB_TIMEOUT_EN
        else if (m_t == CTO) begin
          m_to = 1'b1;
          m_enter_assert();
        end
`endif
      end
      default: begin
        if (soft_rst_req) m_enter_assert();
      end
    endcase
  endtask

  task automatic check_model();
    chk("model rst_out", 32'(rst_out), 32'(m_rst));
    chk("model all_released", 32'(all_released), 32'(m_rst == '0));
    chk("model seq_state", 32'(seq_state), 32'(phase_code(m_phase)));
    chk("model lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_cnt));
`ifdef MEMC_RST_SEQ_CALIB_TIMEOUT_EN
    chk("model calib_timeout", 32'(calib_timeout), 32'(m_to));
`endif
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    e++;
    #1;
    check_model();
  endtask

  task automatic run_to(input int n);
    while (e < n) tick();
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    tick();
    tick();
    chk("reset rst_out", 32'(rst_out), 32'hF);
    chk("reset all_released", 32'(all_released), 32'h0);
    chk("reset lock_loss_cnt", 32'(lock_loss_cnt), 32'h0);
    chk("reset seq_state", 32'(seq_state), 32'(SEQ_ASSERT));
    sys_rst_n = 1'b1;
    e = -1;
  endtask

  typedef struct {
    int            cyc;
    logic [ND-1:0] rst;
    logic          rel;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{19, 4'hF, 1'b0};
    tbl[1] = '{20, 4'hE, 1'b0};
    tbl[2] = '{27, 4'hE, 1'b0};
    tbl[3] = '{28, 4'hC, 1'b0};
    tbl[4] = '{35, 4'hC, 1'b0};
    tbl[5] = '{36, 4'h8, 1'b0};
    tbl[6] = '{43, 4'h8, 1'b0};
    tbl[7] = '{44, 4'h0, 1'b1};
    tbl[8] = '{45, 4'h0, 1'b1};
    tbl[9] = '{60, 4'h0, 1'b1};

    sys_rst_n    = 1'b0;
    pll_lock     = 1'b1;
    calib_done   = 1'b1;
    soft_rst_req = 1'b0;

    // Nominal release timing with lock and calibration both steady.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_to(tbl[i].cyc);
      chk($sformatf("timing rst_out @%0d", tbl[i].cyc), 32'(rst_out), 32'(tbl[i].rst));
      chk($sformatf("timing all_released @%0d", tbl[i].cyc), 32'(all_released), 32'(tbl[i].rel));
    end

    // One-cycle lock glitch after 10 good cycles delays release by 11.
    do_reset();
    run_to(13);
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    run_to(30);
    chk("glitch rst_out @30", 32'(rst_out), 32'hF);
    tick();
    chk("glitch rst_out @31", 32'(rst_out), 32'hE);
    chk("glitch lock_loss_cnt", 32'(lock_loss_cnt), 32'h0);

    // Calibration held off: last domain waits, then releases on the next edge.
    do_reset();
    calib_done = 1'b0;
    run_to(90);
    chk("calib wait rst_out", 32'(rst_out), 32'h8);
    chk("calib wait all_released", 32'(all_released), 32'h0);
    calib_done = 1'b1;
    tick();
    chk("calib done rst_out", 32'(rst_out), 32'h0);
    chk("calib done all_released", 32'(all_released), 32'h1);

    // Lock loss in RUN, then repeated events to saturate the counter.
    run_to(100);
    pll_lock = 1'b0;
    tick();
    chk("lock loss rst_out", 32'(rst_out), 32'hF);
    chk("lock loss count 1", 32'(lock_loss_cnt), 32'h1);
    for (int k = 0; k < 299; k++) begin
      pll_lock = 1'b1;
      repeat (LF + MINA) tick();
      pll_lock = 1'b0;
      tick();
    end
    pll_lock = 1'b1;
    chk("lock loss saturate", 32'(lock_loss_cnt), 32'd255);

    // Soft requests: ignored in RELEASE, honoured in RUN, lock loss wins when coincident.
    do_reset();
    run_to(21);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    run_to(28);
    chk("soft in release rst_out", 32'(rst_out), 32'hC);
    run_to(44);
    chk("soft in release all_released", 32'(all_released), 32'h1);
    run_to(49);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    chk("soft in run rst_out", 32'(rst_out), 32'hF);
    chk("soft in run seq_state", 32'(seq_state), 32'(SEQ_ASSERT));
    run_to(70);
    chk("resequence rst_out @70", 32'(rst_out), 32'hF);
    run_to(71);
    chk("resequence rst_out @71", 32'(rst_out), 32'hE);
    run_to(87);
    chk("resequence rst_out @87", 32'(rst_out), 32'h8);
    run_to(95);
    chk("resequence all_released @95", 32'(all_released), 32'h1);
    chk("soft keeps lock_loss_cnt", 32'(lock_loss_cnt), 32'h0);
    run_to(100);
    soft_rst_req = 1'b1;
    pll_lock     = 1'b0;
    tick();
    soft_rst_req = 1'b0;
    pll_lock     = 1'b1;
    chk("soft+loss lock_loss_cnt", 32'(lock_loss_cnt), 32'h1);

    // Hard reset in the middle of RELEASE.
    run_to(125);
    chk("pre-reset rst_out", 32'(rst_out), 32'hE);
    do_reset();

`ifdef MEMC_RST_SEQ_CALIB_TIMEOUT_EN
    calib_done = 1'b0;
    run_to(142);
    chk("timeout pending state", 32'(seq_state), 32'(SEQ_WAIT_CALIB));
    chk("timeout pending flag", 32'(calib_timeout), 32'h0);
    tick();
    chk("timeout state", 32'(seq_state), 32'(SEQ_ASSERT));
    chk("timeout flag", 32'(calib_timeout), 32'h1);
    chk("timeout rst_out", 32'(rst_out), 32'hF);
    chk("timeout lock_loss_cnt", 32'(lock_loss_cnt), 32'h0);
    run_to(170);
    chk("timeout flag sticky", 32'(calib_timeout), 32'h1);
`else
    calib_done = 1'b0;
    run_to(300);
    chk("no timeout state", 32'(seq_state), 32'(SEQ_WAIT_CALIB));
    chk("no timeout rst_out", 32'(rst_out), 32'h8);
`endif

    // Randomized segments with varying lock stability; model checked every edge.
    do_reset();
    for (int seg = 0; seg < 50; seg++) begin
      int drop_rate;
      int calib_pct;
      drop_rate = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 200 : 20);
      calib_pct = int'($urandom_range(0, 100));
      for (int c = 0; c < 64; c++) begin
        pll_lock     = (drop_rate == 0) ? 1'b1 : ($urandom_range(0, drop_rate - 1) != 0);
        calib_done   = ($urandom_range(0, 99) < calib_pct);
        soft_rst_req = ($urandom_range(0, 29) == 0);
        sys_rst_n    = ($urandom_range(0, 499) != 0);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/memc_rst_sequencer.md
Name: memc_rst_sequencer

Overview:
Parametrised successor to the MCB infrastructure reset logic. Holds up to NUM_DOMAINS downstream reset domains in reset until the PLL lock is stable, then releases them one at a time, domain 0 first. The last domain is also gated on memory calibration completing. Sits between the MCB clock/PLL infrastructure and the user-side logic (DDS/pulse-sequencer/FIFO domains). It re-sequences on PLL lock loss or on a soft reset request.

Parameters:
NUM_DOMAINS, 4, number of reset outputs; 1..16.
MIN_ASSERT, 4, minimum cycles all resets stay asserted on entering ASSERT; at least 1.
LOCK_FILTER, 16, consecutive cycles pll_lock must be high before release starts; at least 1.
STAGE_DELAY, 8, cycles between successive domain releases; at least 1.
CALIB_TIMEOUT, 65535, cycles allowed in WAIT_CALIB; used only with the optional feature.

Ports:
sys_clk  in  1  single clock; all logic on the rising edge.
sys_rst_n  in  1  reset, synchronous, active-low.
pll_lock  in  1  PLL lock, already synchronous to sys_clk.
calib_done  in  1  MCB calibration complete; level signal.
soft_rst_req  in  1  one-cycle pulse requesting a full re-sequence.
rst_out  out  NUM_DOMAINS  per-domain reset, active-high, registered.
all_released  out  1  high when every rst_out bit is 0.
seq_state  out  3  current FSM state encoding, for debug.
lock_loss_cnt  out  8  saturating count of lock-loss events.
calib_timeout  out  1  sticky timeout flag; exists only with the optional feature.

Behaviour:
- Reset (sys_rst_n = 0 at an edge) sets, at that edge:
  - rst_out = all ones, all_released = 0, lock_loss_cnt = 0, calib_timeout = 0.
  - state = ASSERT, all counters cleared.
  - Applies mid-operation too.
- FSM states: ASSERT, WAIT_LOCK, RELEASE, WAIT_CALIB, RUN.
- ASSERT:
  - rst_out = all ones.
  - Stays exactly MIN_ASSERT cycles, then goes to WAIT_LOCK.
- WAIT_LOCK:
  - Filter counter increments while pll_lock = 1 and clears to 0 on any cycle with pll_lock = 0.
  - When the counter reaches LOCK_FILTER, go to RELEASE.
- RELEASE:
  - rst_out[0] clears on the first edge in RELEASE.
  - rst_out[i] clears STAGE_DELAY cycles after rst_out[i-1], for i up to NUM_DOMAINS-2.
  - STAGE_DELAY cycles after bit NUM_DOMAINS-2 clears, go to WAIT_CALIB.
  - If NUM_DOMAINS = 1, go straight to WAIT_CALIB.
- WAIT_CALIB:
  - rst_out[NUM_DOMAINS-1] clears on the first edge where calib_done = 1.
  - all_released rises on that same edge, and the FSM goes to RUN.
- RUN: holds; all_released = 1.
- Lock loss:
  - Applies when pll_lock = 0 is sampled in RELEASE, WAIT_CALIB or RUN.
  - Next edge: rst_out = all ones, all_released = 0, state = ASSERT.
  - lock_loss_cnt increments and saturates at 255.
- soft_rst_req:
  - Honoured only in RUN: go to ASSERT, lock_loss_cnt unchanged.
  - Ignored in all other states.
- Simultaneous lock loss and soft_rst_req in RUN: treated as lock loss, so the count increments.
- Released rst_out bits never reassert except by going to ASSERT.
- Counter widths derived with $clog2 of the largest count; no wrap inside any state.

Optional Feature:
Macro MEMC_RST_SEQ_CALIB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT_CALIB.
  - Reaching CALIB_TIMEOUT sets calib_timeout (sticky until sys_rst_n) and goes to ASSERT, forcing recalibration.
  - lock_loss_cnt is not incremented by a timeout.
- Undefined:
  - No counter; WAIT_CALIB waits indefinitely.
  - The calib_timeout port is absent.

Decomposition:
- Package memc_rst_pkg:
  - State enum plus its 3-bit encoding, matching seq_state.
  - LOCK_CNT_W = 8.
  - Function to compute counter widths.
- One sub-module, memc_lock_filter: the consecutive-high debounce counter on pll_lock, with a clear input and a stable output, reused by other PLL consumers.

Test Plan:
Common setup: NUM_DOMAINS=4, MIN_ASSERT=4, LOCK_FILTER=16, STAGE_DELAY=8. Edge 0 is the first edge with sys_rst_n = 1.
1. pll_lock and calib_done held at 1 -> rst_out[0] falls at edge 20, [1] at 28, [2] at 36, [3] at 44; all_released rises at edge 44.
2. Same as 1, plus a one-cycle pll_lock = 0 glitch after 10 lock cycles in WAIT_LOCK -> release delayed by 11 cycles; lock_loss_cnt stays 0.
3. calib_done held at 0 -> rst_out = 4'b1000 indefinitely; raise calib_done -> rst_out[3] = 0 and all_released = 1 on the next edge.
4. Lock loss:
   - Drop pll_lock in RUN -> rst_out = 4'hF on the next edge, lock_loss_cnt = 1.
   - 300 lock-loss cycles -> lock_loss_cnt = 255.
5. soft_rst_req:
   - Pulse during RELEASE -> ignored.
   - Pulse in RUN -> full re-sequence with the timing of scenario 1; lock_loss_cnt unchanged.
   - Pulse together with pll_lock = 0 -> lock_loss_cnt increments.
6. Reset and timeout:
   - sys_rst_n = 0 mid-RELEASE -> all outputs return to reset values at that edge.
   - With the macro defined and CALIB_TIMEOUT=100, calib_done = 0 -> calib_timeout = 1 and the FSM re-enters ASSERT after 100 cycles.
